// File: rtl/nand_flash_ctrl_if.sv
// ----------------------------------------------------------------------------
// nand_flash_ctrl_if
// Host-side command/response bundle for nand_flash_ctrl.
//   cmd_valid/cmd_ready : command handshake (accept on valid && ready)
//   cmd_op              : 00 read, 01 write, 10 erase, 11 reserved
//   cmd_addr/cmd_wdata  : command address and write data
//   rsp_valid           : one-cycle response pulse, no backpressure
//   rsp_rdata/rsp_err   : response data and error flag (qualified by rsp_valid)
//   busy                : controller not in IDLE
// master modport = system logic issuing commands, slave modport = controller.
// ----------------------------------------------------------------------------
interface nand_flash_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/nand_flash_ctrl.sv
// ----------------------------------------------------------------------------
// nand_flash_ctrl
// Sequences read / write / full-array erase commands onto a single-port NAND
// array whose data_out is registered (read data appears one cycle after
// mem_re). One command in flight at a time; one-cycle response per command.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   host         : nand_flash_ctrl_if.slave command/response bundle
//   mem_we       : array write strobe
//   mem_re       : array read strobe
//   mem_erase    : array full erase strobe
//   mem_addr     : array address (latched on accept)
//   mem_wdata    : array write data (latched on accept)
//   mem_rdata    : array data_out
//
// Optional feature macro: NAND_CTRL_VERIFY_EN
//   When defined, each write is read back (VFY_ISSUE/VFY_CAP) and rsp_err
//   flags a read-back that differs from the written data.
// ----------------------------------------------------------------------------
module nand_flash_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int ERASE_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   nand_flash_ctrl_if.slave  host,
   output logic              mem_we,
   output logic              mem_re,
   output logic              mem_erase,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b10;

   localparam logic [7:0] ERASE_WAIT_C = 8'(ERASE_WAIT);

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_RD_ISSUE = 4'd1,
      ST_RD_CAP   = 4'd2,
      ST_WR       = 4'd3,
`ifdef NAND_CTRL_VERIFY_EN
      ST_VFY_ISSUE = 4'd4,
      ST_VFY_CAP   = 4'd5,
`endif
      ST_ER_PULSE = 4'd6,
      ST_ER_WAIT  = 4'd7,
      ST_RESP     = 4'd8
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] rsp_rdata_r;
   logic              rsp_err_r;
   logic [7:0]        erase_cnt_r;

   // Control FSM: command accept, strobe sequencing, response data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         rsp_rdata_r <= '0;
         rsp_err_r   <= 1'b0;
         erase_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // cmd_ready is exactly "state is IDLE", so valid alone accepts here.
               if (host.cmd_valid) begin
                  mem_addr_r  <= host.cmd_addr;
                  mem_wdata_r <= host.cmd_wdata;
                  case (host.cmd_op)
                     OP_READ: begin
                        rsp_err_r <= 1'b0;
                        state_r   <= ST_RD_ISSUE;
                     end
                     OP_WRITE: begin
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b0;
                        state_r     <= ST_WR;
                     end
                     OP_ERASE: begin
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b0;
                        state_r     <= ST_ER_PULSE;
                     end
                     default: begin
                        // Reserved opcode: no array access, respond with error.
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b1;
                        state_r     <= ST_RESP;
                     end
                  endcase
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RD_ISSUE: begin
               state_r <= ST_RD_CAP;
            end
            ST_RD_CAP: begin
               // Array output register now holds the addressed word.
               rsp_rdata_r <= mem_rdata;
               state_r     <= ST_RESP;
            end
            ST_WR: begin
`ifdef NAND_CTRL_VERIFY_EN
               state_r <= ST_VFY_ISSUE;
`else
               state_r <= ST_RESP;
`endif
            end
`ifdef NAND_CTRL_VERIFY_EN
            ST_VFY_ISSUE: begin
               state_r <= ST_VFY_CAP;
            end
            ST_VFY_CAP: begin
               rsp_rdata_r <= mem_rdata;
               rsp_err_r   <= (mem_rdata != mem_wdata_r);
               state_r     <= ST_RESP;
            end
`endif
            ST_ER_PULSE: begin
               erase_cnt_r <= ERASE_WAIT_C;
               state_r     <= ST_ER_WAIT;
            end
            ST_ER_WAIT: begin
               // Counter starts at ERASE_WAIT on the first wait cycle, so
               // leaving when it reads 1 gives exactly ERASE_WAIT wait cycles.
               if (erase_cnt_r <= 8'd1) begin
                  erase_cnt_r <= 8'd0;
                  state_r     <= ST_RESP;
               end else begin
                  erase_cnt_r <= erase_cnt_r - 8'd1;
                  state_r     <= ST_ER_WAIT;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobes and handshake are decoded from the state register so that they
   // fall together with the asynchronous reset and are mutually exclusive.
   assign mem_we    = (state_r == ST_WR);
`ifdef NAND_CTRL_VERIFY_EN
   assign mem_re    = (state_r == ST_RD_ISSUE) || (state_r == ST_VFY_ISSUE);
`else
   assign mem_re    = (state_r == ST_RD_ISSUE);
`endif
   assign mem_erase = (state_r == ST_ER_PULSE);
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

   assign host.cmd_ready = (state_r == ST_IDLE);
   assign host.busy      = (state_r != ST_IDLE);
   assign host.rsp_valid = (state_r == ST_RESP);
   assign host.rsp_rdata = rsp_rdata_r;
   assign host.rsp_err   = rsp_err_r;

endmodule
